// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
//   STATE_W   - width of the debug state output
//   XZR_IDX   - register index of the zero register (never a real dependency)
//   TIMER_W   - width of the memory-wait watchdog timer (covers 2..255)
//   hz_state_e - controller states RUN / BR_WAIT / MEM_WAIT
package hazard_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned TIMER_W = 8;
  localparam logic [4:0]  XZR_IDX = 5'd31;

  typedef enum logic [STATE_W-1:0] {
    RUN      = 2'd0,
    BR_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_lu_detect.sv
// hazard_lu_detect: combinational load-use hazard comparator.
// Flags when the instruction in EX is a load whose destination is read by
// the instruction in ID. Writes to the zero register never create a hazard.
//   ex_loadop_i   - EX instruction is a load
//   ex_rd_i       - EX destination register
//   id_rn_i/rm_i  - ID source registers
//   id_uses_rn_i/rm_i - ID instruction actually reads that source
//   lu_o          - load-use hazard present
module hazard_lu_detect
  import hazard_pkg::*;
(
  input  logic       ex_loadop_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rn_i,
  input  logic [4:0] id_rm_i,
  input  logic       id_uses_rn_i,
  input  logic       id_uses_rm_i,
  output logic       lu_o
);

  logic rn_hit;
  logic rm_hit;

  always_comb begin
    rn_hit = id_uses_rn_i & (id_rn_i == ex_rd_i);
    rm_hit = id_uses_rm_i & (id_rm_i == ex_rd_i);
    lu_o   = ex_loadop_i & (ex_rd_i != XZR_IDX) & (rn_hit | rm_hit);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage CPU.
// Owns PC / IF-ID enables, IF-ID flush, ID-EX bubble and the back-end hold.
// Resolves load-use stalls, taken-branch redirects (PC-relative and BR) and
// multi-cycle data-memory accesses with a timeout watchdog.
//
// Ports:
//   clk, reset (sync, active-low)
//   id_rn, id_rm, id_uses_rn, id_uses_rm, ex_loadop, ex_rd - hazard sources
//   id_brtaken, id_br_op   - branch events in ID
//   mem_req, mem_ack       - data-memory handshake for the MEM stage
//   pc_we, ifid_we, ifid_flush, idex_bubble, pipe_hold, pc_sel_reg - controls
//   mem_err                - sticky memory-timeout flag
//   state                  - current FSM state (debug)
//   stall_cnt, flush_cnt   - performance counters (only with HAZARD_PERF_EN)
//
// Build option: define HAZARD_PERF_EN to add the performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         id_rn,
  input  logic [4:0]         id_rm,
  input  logic               id_uses_rn,
  input  logic               id_uses_rm,
  input  logic               ex_loadop,
  input  logic [4:0]         ex_rd,
  input  logic               id_brtaken,
  input  logic               id_br_op,
  input  logic               mem_req,
  input  logic               mem_ack,
  output logic               pc_we,
  output logic               ifid_we,
  output logic               ifid_flush,
  output logic               idex_bubble,
  output logic               pipe_hold,
  output logic               pc_sel_reg,
  output logic               mem_err,
  output logic [STATE_W-1:0] state
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  localparam logic [TIMER_W-1:0] TIMEOUT_V = TIMER_W'(MEM_TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

  hz_state_e          state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               mem_err_q, mem_err_d;

  logic lu;
  logic mem_stall;
  logic run_ev;

  logic pc_we_c, ifid_we_c, flush_c, bubble_c, hold_c, sel_c;

  hazard_lu_detect u_lu (
    .ex_loadop_i  (ex_loadop),
    .ex_rd_i      (ex_rd),
    .id_rn_i      (id_rn),
    .id_rm_i      (id_rm),
    .id_uses_rn_i (id_uses_rn),
    .id_uses_rm_i (id_uses_rm),
    .lu_o         (lu)
  );

  assign mem_stall = mem_req & ~mem_ack;

  // The cycle that ends a memory wait (ack or timeout) behaves as a plain RUN
  // cycle, so the held ID instruction's lu/branch is evaluated exactly then.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    mem_err_d = mem_err_q;
    pc_we_c   = 1'b1;
    ifid_we_c = 1'b1;
    flush_c   = 1'b0;
    bubble_c  = 1'b0;
    hold_c    = 1'b0;
    sel_c     = 1'b0;
    run_ev    = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          pc_we_c   = 1'b0;
          ifid_we_c = 1'b0;
          hold_c    = 1'b1;
          state_d   = MEM_WAIT;
          timer_d   = TIMER_ONE;
        end else begin
          run_ev = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          state_d = RUN;
          timer_d = '0;
          run_ev  = 1'b1;
        end else if (timer_q == TIMEOUT_V) begin
          mem_err_d = 1'b1;
          state_d   = RUN;
          timer_d   = '0;
          run_ev    = 1'b1;
        end else begin
          pc_we_c   = 1'b0;
          ifid_we_c = 1'b0;
          hold_c    = 1'b1;
          timer_d   = timer_q + TIMER_ONE;
        end
      end
      BR_WAIT: begin
        flush_c = 1'b1;
        sel_c   = 1'b1;
        if (mem_stall) begin
          pc_we_c = 1'b0;
          hold_c  = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (run_ev) begin
      if (lu) begin
        pc_we_c   = 1'b0;
        ifid_we_c = 1'b0;
        bubble_c  = 1'b1;
      end else if (id_br_op) begin
        flush_c = 1'b1;
        pc_we_c = 1'b0;
        state_d = BR_WAIT;
      end else if (id_brtaken) begin
        flush_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= RUN;
      timer_q   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Reset forces a safe pipeline: nothing advances, NOPs enter IF/ID and ID/EX.
  assign pc_we       = reset & pc_we_c;
  assign ifid_we     = reset & ifid_we_c;
  assign ifid_flush  = ~reset | flush_c;
  assign idex_bubble = ~reset | bubble_c;
  assign pipe_hold   = reset & hold_c;
  assign pc_sel_reg  = reset & sel_c;
  assign mem_err     = mem_err_q;
  assign state       = state_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_we)     stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ifid_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rn, id_rm, ex_rd;
  logic       id_uses_rn, id_uses_rm, ex_loadop;
  logic       id_brtaken, id_br_op, mem_req, mem_ack;
  logic       pc_we, ifid_we, ifid_flush, idex_bubble, pipe_hold, pc_sel_reg, mem_err;
  logic [1:0] state;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_rn       (id_rn),
    .id_rm       (id_rm),
    .id_uses_rn  (id_uses_rn),
    .id_uses_rm  (id_uses_rm),
    .ex_loadop   (ex_loadop),
    .ex_rd       (ex_rd),
    .id_brtaken  (id_brtaken),
    .id_br_op    (id_br_op),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .pc_we       (pc_we),
    .ifid_we     (ifid_we),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .pipe_hold   (pipe_hold),
    .pc_sel_reg  (pc_sel_reg),
    .mem_err     (mem_err),
    .state       (state)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  // Expected outputs for one cycle: {pc_we, ifid_we, flush, bubble, hold, sel, err, state}
  typedef struct packed {
    logic [31:0] stalls;
    logic [31:0] flushes;
    logic [8:0]  ctl;
  } exp_t;

  exp_t q[$];
  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  int unsigned cyc_no     = 0;

  // Reference model: cycles already spent waiting on memory (-1 = not waiting),
  // a pending register-branch redirect, the sticky error and event tallies.
  int          waited     = -1;
  bit          br_pending = 1'b0;
  bit          err        = 1'b0;
  int unsigned m_stalls   = 0;
  int unsigned m_flushes  = 0;

  task automatic tick();
    logic pw, iw, fl, bb, hd, sl;
    logic [1:0] st;
    bit lu, stall_mem, run_ev, new_err;
    exp_t e;
    st = (waited >= 0) ? 2'd2 : (br_pending ? 2'd1 : 2'd0);
    e.stalls  = m_stalls;
    e.flushes = m_flushes;
    if (!reset) begin
      e.ctl = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, err, st};
      waited = -1; br_pending = 1'b0; err = 1'b0;
      m_stalls = 0; m_flushes = 0;
    end else begin
      lu = ex_loadop && (ex_rd != 5'd31) &&
           ((id_uses_rn && id_rn == ex_rd) || (id_uses_rm && id_rm == ex_rd));
      stall_mem = mem_req && !mem_ack;
      pw = 1; iw = 1; fl = 0; bb = 0; hd = 0; sl = 0; run_ev = 0;
      new_err = err;
      if (waited >= 0) begin
        if (mem_ack) begin
          waited = -1; run_ev = 1;
        end else if (waited >= TO) begin
          waited = -1; new_err = 1; run_ev = 1;
        end else begin
          pw = 0; iw = 0; hd = 1; waited++;
        end
      end else if (br_pending) begin
        fl = 1; sl = 1;
        if (stall_mem) begin pw = 0; hd = 1; end
        else br_pending = 1'b0;
      end else if (stall_mem) begin
        pw = 0; iw = 0; hd = 1; waited = 1;
      end else begin
        run_ev = 1;
      end
      if (run_ev) begin
        if (lu) begin pw = 0; iw = 0; bb = 1; end
        else if (id_br_op) begin fl = 1; pw = 0; br_pending = 1'b1; end
        else if (id_brtaken) fl = 1;
      end
      e.ctl = {pw, iw, fl, bb, hd, sl, err, st};
      err = new_err;
      if (!pw) m_stalls++;
      if (fl)  m_flushes++;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic r, input logic ld, input logic [4:0] rd,
                     input logic [4:0] rn, input logic urn,
                     input logic [4:0] rm, input logic urm,
                     input logic bt, input logic bo, input logic mr, input logic ma);
    reset = r; ex_loadop = ld; ex_rd = rd;
    id_rn = rn; id_uses_rn = urn; id_rm = rm; id_uses_rm = urm;
    id_brtaken = bt; id_br_op = bo; mem_req = mr; mem_ack = ma;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle on the falling edge.
  initial begin
    exp_t e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_hold, pc_sel_reg, mem_err, state};
        compared++;
        if (act !== e.ctl) begin
          mismatched++;
          $display("FAIL ctl cycle %0d: got pwe,iwe,fl,bb,hd,sel,err,st=%b required %b",
                   cyc_no, act, e.ctl);
        end
`ifdef HAZARD_PERF_EN
        compared++;
        if ({stall_cnt, flush_cnt} !== {e.stalls, e.flushes}) begin
          mismatched++;
          $display("FAIL perf cycle %0d: got stall=%0d flush=%0d required stall=%0d flush=%0d",
                   cyc_no, stall_cnt, flush_cnt, e.stalls, e.flushes);
        end
`endif
        cyc_no++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [4:0] rd, rn, rm;
    int t;
    reset = 0; ex_loadop = 0; ex_rd = 0; id_rn = 0; id_rm = 0;
    id_uses_rn = 0; id_uses_rm = 0; id_brtaken = 0; id_br_op = 0;
    mem_req = 0; mem_ack = 0;
    @(posedge clk);
    #1;

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // load-use, then the bubble clears the load in EX
    cyc(1, 1, 5, 5, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    // rm-side hazard and a zero-register "hazard"
    cyc(1, 1, 7, 1, 1, 7, 1, 0, 0, 0, 0);
    cyc(1, 1, 31, 31, 1, 31, 1, 0, 0, 0, 0);
    cyc(1, 1, 7, 7, 0, 7, 0, 0, 0, 0, 0);
    // taken PC-relative branch
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(1);
    // register branch: two flushed slots
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);
    // 4-cycle memory access, then zero-wait access
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, (i == 3));
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    // timeout with no ack; error stays set afterwards
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    // ack on the very cycle the timer expires
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, (i == 4));
    idle(1);
    // lu together with a taken branch: bubble first, flush next cycle
    cyc(1, 1, 3, 3, 1, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 3, 1, 0, 0, 1, 0, 0, 0);
    idle(1);
    // memory stall with lu pending: bubble only in the release cycle
    cyc(1, 1, 4, 4, 1, 0, 0, 0, 0, 1, 0);
    cyc(1, 1, 4, 4, 1, 0, 0, 0, 0, 1, 0);
    cyc(1, 1, 4, 4, 1, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0);
    // register branch whose BR_WAIT cycle meets a memory stall
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    // reset in the middle of a memory wait
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      t  = $urandom_range(0, 4);
      rd = (t == 4) ? 5'd31 : 5'(t);
      t  = $urandom_range(0, 4);
      rn = (t == 4) ? 5'd31 : 5'(t);
      t  = $urandom_range(0, 4);
      rm = (t == 4) ? 5'd31 : 5'(t);
      cyc(($urandom_range(0, 99) != 0),
          ($urandom_range(0, 99) < 40), rd,
          rn, ($urandom_range(0, 1) == 1),
          rm, ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 6),
          ($urandom_range(0, 99) < 25), ($urandom_range(0, 1) == 1));
    end
    idle(1);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d unchecked entries required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
